// File: rtl/arb_pkg.sv
// Shared types for the fetch/data memory arbiter: FSM state encoding and
// the served-port selector.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        FETCH = 2'd2,
        DONE  = 2'd3
    } arb_state_e;

    typedef enum logic {
        SEL_D = 1'b0,
        SEL_I = 1'b1
    } port_sel_e;

endpackage

// File: rtl/arb_watchdog.sv
// Wait-cycle counter for an outstanding memory access. Held clear while
// start is high; counts cycles with ready low. expired is raised in the
// wait cycle whose edge brings the count to TIMEOUT, so the FSM leaves on
// that same edge.
module arb_watchdog #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic start,
    input  logic ready,
    output logic expired
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Next count: clear on start, otherwise count unready cycles up to TIMEOUT.
    always_comb begin
        cnt_d = cnt_q;
        if (start) begin
            cnt_d = '0;
        end else if (!ready && (cnt_q != CW'(TIMEOUT))) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clock) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign expired = !ready && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port memory between the instruction-fetch
// port and the data port. Data wins ties; each access runs
// IDLE -> DATA/FETCH -> DONE -> IDLE and pulses the served port's valid
// in DONE. Optional macro ARB_TIMEOUT_EN adds a wait-cycle watchdog that
// abandons a stuck access, returns zero read data and pulses err.
module mem_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    output logic [XLEN-1:0] if_rdata,
    output logic            if_valid,
    output logic            if_stall,
    input  logic            d_load,
    input  logic            d_store,
    input  logic [XLEN-1:0] d_addr,
    input  logic [XLEN-1:0] d_wdata,
    output logic [XLEN-1:0] d_rdata,
    output logic            d_valid,
    output logic            d_stall,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_ready,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            err
);

    arb_state_e      state_q, state_d;
    port_sel_e       sel;
    logic            mem_req_q, mem_req_d;
    logic            mem_we_q, mem_we_d;
    logic [XLEN-1:0] mem_addr_q, mem_addr_d;
    logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
    logic [XLEN-1:0] if_rdata_q, if_rdata_d;
    logic [XLEN-1:0] d_rdata_q, d_rdata_d;
    logic            if_valid_q, if_valid_d;
    logic            d_valid_q, d_valid_d;
    logic            d_any;

    assign d_any = d_load | d_store;
    assign sel   = (state_q == FETCH) ? SEL_I : SEL_D;

`ifdef ARB_TIMEOUT_EN
    logic wd_expired;
    logic err_q, err_d;

    arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clock   (clock),
        .reset   (reset),
        .start   (state_q == IDLE),
        .ready   (mem_ready),
        .expired (wd_expired)
    );
`endif

    // Next-state and registered-output logic; everything holds by default.
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_valid_d  = 1'b0;
        d_valid_d   = 1'b0;
`ifdef ARB_TIMEOUT_EN
        err_d       = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (d_any) begin
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    mem_we_d    = d_store;   // load+store together is a store
                    mem_req_d   = 1'b1;
                    state_d     = DATA;
                end else if (if_req) begin
                    mem_addr_d  = if_addr;
                    mem_we_d    = 1'b0;
                    mem_req_d   = 1'b1;
                    state_d     = FETCH;
                end
            end
            DATA, FETCH: begin
                if (mem_ready) begin
                    mem_req_d = 1'b0;
                    state_d   = DONE;
                    if (sel == SEL_I) begin
                        if_valid_d = 1'b1;
                        if_rdata_d = mem_rdata;
                    end else begin
                        d_valid_d = 1'b1;
                        if (!mem_we_q) d_rdata_d = mem_rdata;
                    end
                end
`ifdef ARB_TIMEOUT_EN
                else if (wd_expired) begin
                    mem_req_d = 1'b0;
                    state_d   = DONE;
                    err_d     = 1'b1;
                    if (sel == SEL_I) begin
                        if_valid_d = 1'b1;
                        if_rdata_d = '0;
                    end else begin
                        d_valid_d = 1'b1;
                        if (!mem_we_q) d_rdata_d = '0;
                    end
                end
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any in-flight access.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_valid_q  <= 1'b0;
            d_valid_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            if_valid_q  <= if_valid_d;
            d_valid_q   <= d_valid_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    // Timeout error pulse, aligned with the valid of the abandoned access.
    always_ff @(posedge clock) begin
        if (reset) err_q <= 1'b0;
        else       err_q <= err_d;
    end
    assign err = err_q;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
    assign err = 1'b0;
`endif

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign if_valid  = if_valid_q;
    assign d_valid   = d_valid_q;
    assign if_stall  = if_req & ~if_valid_q;
    assign d_stall   = d_any & ~d_valid_q;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares one single-port memory between the CPU's instruction-fetch port and its data (load/store) port. Sits between the pipelined core and the unified memory. It serializes requests with a 4-state FSM, data taking priority, and drives per-port stall signals that the core ORs into its hazard pause. It also returns registered read data with a one-cycle valid pulse.

Parameters:
XLEN, 32, data/address width
TIMEOUT, 255, max wait cycles for mem_ready (used only with ARB_TIMEOUT_EN)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
if_req  in  1  fetch request, held until if_valid
if_addr  in  XLEN  fetch address (pc)
if_rdata  out  XLEN  fetched instruction, registered
if_valid  out  1  one-cycle pulse: fetch complete
if_stall  out  1  fetch pending and not complete
d_load  in  1  data load request, held until d_valid
d_store  in  1  data store request, held until d_valid
d_addr  in  XLEN  data address
d_wdata  in  XLEN  store word (already byte-merged by core)
d_rdata  out  XLEN  load data, registered
d_valid  out  1  one-cycle pulse: data access complete
d_stall  out  1  data access pending and not complete
mem_req  out  1  memory request, registered
mem_we  out  1  write enable, registered
mem_addr  out  XLEN  memory address, registered
mem_wdata  out  XLEN  memory write data, registered
mem_ready  in  1  memory accepts/completes the current request this cycle
mem_rdata  in  XLEN  read data, valid when mem_ready=1
err  out  1  one-cycle pulse on timeout; tied 0 without ARB_TIMEOUT_EN

Behaviour:
- Clock is clock. Reset is synchronous and active-high on reset.
- Reset values: state=IDLE; mem_req, mem_we, if_valid, d_valid, err = 0; mem_addr, mem_wdata, if_rdata, d_rdata = 0.
- States:
  - IDLE:
    - If d_load|d_store: latch d_addr/d_wdata into mem_addr/mem_wdata, set mem_we=d_store, mem_req=1, go to DATA.
    - Else if if_req: latch if_addr, set mem_we=0, mem_req=1, go to FETCH.
    - Else stay in IDLE.
  - DATA/FETCH: hold mem_req/mem_we/mem_addr/mem_wdata stable.
    - On mem_ready=1: mem_req←0 and go to DONE.
    - In DATA with mem_we=0: d_rdata←mem_rdata. A store leaves d_rdata unchanged.
    - In FETCH: if_rdata←mem_rdata.
  - DONE: the served port's valid is high for exactly this cycle. All requests are ignored. Next state is IDLE.
- Priority: data wins over fetch when both are asserted in IDLE. Fetch is issued in the IDLE following DONE. Fetch cannot starve, because the core stalls on d_stall and drops the data request after d_valid.
- Latency: request seen in IDLE at cycle 0 → mem_req=1 at cycle 1. With mem_ready=1 at cycle 1 → valid at cycle 2 → IDLE at cycle 3. Each extra wait cycle of memory adds 1.
- Stalls (combinational):
  - if_stall = if_req & ~if_valid
  - d_stall = (d_load|d_store) & ~d_valid
- If d_load and d_store are both asserted, it is treated as a store (mem_we=1).
- rdata registers hold their value until the next completion on the same port.
- Reset mid-transaction: the next edge returns to IDLE with mem_req=0. The in-flight access is abandoned and no valid is pulsed. Memory must tolerate a request being dropped.
- Requests deasserted while in DATA/FETCH do not cancel the access; it completes normally and valid still pulses.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- When defined:
  - A counter clears on entry to DATA/FETCH and increments each cycle while mem_ready=0.
  - When it reaches TIMEOUT: mem_req←0, go to DONE, write 0 into the served port's rdata (loads/fetches only), and pulse err with the valid.
  - Counter width is $clog2(TIMEOUT+1).
- When undefined: no counter, err is constant 0, and the block waits indefinitely.

Decomposition:
- Package arb_pkg holds:
  - state enum: IDLE=2'd0, DATA=2'd1, FETCH=2'd2, DONE=2'd3
  - port-select constant: SEL_D / SEL_I
- One sub-module, arb_watchdog: the timeout counter with inputs clock, reset, start, ready and output expired. It is instantiated only under ARB_TIMEOUT_EN.

Test Plan:
- Zero-wait load: d_load=1, d_addr=0x100, mem_rdata=0xDEADBEEF with mem_ready=1 → mem_req at cycle 1, d_valid pulse at cycle 2, d_rdata=0xDEADBEEF, d_stall=1 on cycles 0–1.
- Contention: if_req=1 and d_store=1 at cycle 0 (d_addr=0x200, d_wdata=0x12345678), mem_ready always 1 → store issued first with mem_we=1, d_valid at cycle 2; fetch mem_req at cycle 4, if_valid at cycle 5.
- Wait states: fetch with mem_ready low for 3 cycles → mem_addr stable for 4 cycles, if_valid exactly one cycle after mem_ready, if_stall high throughout.
- Reset mid-DATA: assert reset in cycle 2 of a stalled load → next cycle mem_req=0, d_valid never pulses, state IDLE.
- Store preserves d_rdata: load returns 0xA5A5A5A5, then store → d_rdata stays 0xA5A5A5A5.
- ARB_TIMEOUT_EN with TIMEOUT=4, mem_ready held 0 → err and d_valid pulse together after 4 wait cycles, d_rdata=0, mem_req dropped.
